delay_tap_loader: RTL and testbench

DELAY_TAP_LOADER -- requirements
Module: delay_tap_loader

---
 rtl/delay_tap_loader_if.sv | 31 +++
 rtl/delay_tap_loader.sv | 181 ++++++++++++++++++
 tb/tb_delay_tap_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_tap_loader_if.sv
// Bundles the tap-request handshake, delay-element control and status lines.
// master: tap requester / delay-element side (drives req_*, err_clr, dly_cntvalueout)
// slave : delay_tap_loader (drives ready, dly_* controls, cur_tap and status pulses)
interface delay_tap_loader_if #(
    parameter int unsigned TAP_W = 9
) ();
    logic             req_valid;
    logic [TAP_W-1:0] req_tap;
    logic             req_ready;
    logic             err_clr;
    logic             dly_en_vtc;
    logic             dly_load;
    logic [TAP_W-1:0] dly_cntvaluein;
    logic [TAP_W-1:0] dly_cntvalueout;
    logic [TAP_W-1:0] cur_tap;
    logic             done;
    logic             clamped;
    logic             err_sticky;

    modport master (
        output req_valid, req_tap, err_clr, dly_cntvalueout,
        input  req_ready, dly_en_vtc, dly_load, dly_cntvaluein, cur_tap,
               done, clamped, err_sticky
    );

    modport slave (
        input  req_valid, req_tap, err_clr, dly_cntvalueout,
        output req_ready, dly_en_vtc, dly_load, dly_cntvaluein, cur_tap,
               done, clamped, err_sticky
    );
endinterface

// File: rtl/delay_tap_loader.sv
// Loads an absolute tap value into a VAR_LOAD delay element: drops EN_VTC,
// waits, pulses LOAD, lets the element settle, verifies CNTVALUEOUT (with
// bounded retries) and restores EN_VTC.
// Ports: clk_div  - delay-element control clock (rising edge)
//        rst_n    - asynchronous active-low reset
//        bus      - slave modport: request handshake, delay-element control,
//                   readback, cur_tap and done/clamped/err_sticky status
module delay_tap_loader #(
    parameter int unsigned TAP_W       = 9,
    parameter int unsigned MAX_TAP     = 511,
    parameter int unsigned VTC_WAIT    = 10,
    parameter int unsigned SETTLE_WAIT = 4,
    parameter int unsigned RETRIES     = 1
) (
    input  logic                clk_div,
    input  logic                rst_n,
    delay_tap_loader_if.slave   bus
);

    localparam int unsigned WAIT_MAX = (VTC_WAIT > SETTLE_WAIT) ? VTC_WAIT : SETTLE_WAIT;
    localparam int unsigned CNT_W    = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam int unsigned ATT_W    = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);

    localparam logic [TAP_W-1:0] MAX_TAP_V   = TAP_W'(MAX_TAP);
    localparam logic [CNT_W-1:0] VTC_LAST    = CNT_W'((VTC_WAIT == 0) ? 0 : VTC_WAIT - 1);
    // SETTLE spans the cycle in which the element takes the load plus SETTLE_WAIT cycles
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_WAIT);
    localparam logic [ATT_W-1:0] ATT_MAX     = ATT_W'(RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        VTC_OFF,
        LOAD,
        SETTLE,
        CHECK,
        VTC_ON
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ATT_W-1:0] attempt_q, attempt_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic [TAP_W-1:0] cntin_q, cntin_d;
    logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
    logic             en_vtc_q, en_vtc_d;
    logic             load_q, load_d;
    logic             done_q, done_d;
    logic             clamped_q, clamped_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    logic             over_max;
    logic [TAP_W-1:0] req_tgt;

    assign over_max = bus.req_tap > MAX_TAP_V;
    assign req_tgt  = over_max ? MAX_TAP_V : bus.req_tap;

    // State and registered outputs
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            attempt_q <= '0;
            target_q  <= '0;
            cntin_q   <= '0;
            cur_tap_q <= '0;
            en_vtc_q  <= 1'b1;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            attempt_q <= attempt_d;
            target_q  <= target_d;
            cntin_q   <= cntin_d;
            cur_tap_q <= cur_tap_d;
            en_vtc_q  <= en_vtc_d;
            load_q    <= load_d;
            done_q    <= done_d;
            clamped_q <= clamped_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        attempt_d = attempt_q;
        target_d  = target_q;
        cntin_d   = cntin_q;
        cur_tap_d = cur_tap_q;
        en_vtc_d  = en_vtc_q;
        load_d    = 1'b0;
        done_d    = 1'b0;
        clamped_d = 1'b0;
        // a set in CHECK below overrides the clear
        err_d     = err_q & ~bus.err_clr;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    target_d  = req_tgt;
                    cntin_d   = req_tgt;
                    clamped_d = over_max;
                    attempt_d = '0;
                    cnt_d     = '0;
                    en_vtc_d  = 1'b0;
                    if (VTC_WAIT == 0) begin
                        state_d = LOAD;
                        load_d  = 1'b1;
                    end else begin
                        state_d = VTC_OFF;
                    end
                end
            end
            VTC_OFF: begin
                if (cnt_q == VTC_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                    load_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = (SETTLE_WAIT == 0) ? CHECK : SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (bus.dly_cntvalueout == target_q) begin
                    cur_tap_d = target_q;
                    en_vtc_d  = 1'b1;
                    done_d    = 1'b1;
                    state_d   = VTC_ON;
                end else if (attempt_q < ATT_MAX) begin
                    // retry with VTC still disabled
                    attempt_d = attempt_q + 1'b1;
                    load_d    = 1'b1;
                    state_d   = LOAD;
                end else begin
                    err_d    = 1'b1;
                    en_vtc_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = VTC_ON;
                end
            end
            VTC_ON: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                en_vtc_d = 1'b1;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    assign bus.req_ready      = ready_q;
    assign bus.dly_en_vtc     = en_vtc_q;
    assign bus.dly_load       = load_q;
    assign bus.dly_cntvaluein = cntin_q;
    assign bus.cur_tap        = cur_tap_q;
    assign bus.done           = done_q;
    assign bus.clamped        = clamped_q;
    assign bus.err_sticky     = err_q;

endmodule

// File: tb/tb_delay_tap_loader.sv
// Testbench for delay_tap_loader: behavioural delay-element readback model
// driven from the request task, randomized requests, and a reference model
// of target / load count / latency / status computed from the timing rules.
module tb_delay_tap_loader;

    localparam int unsigned TAP_W       = 10;
    localparam int unsigned MAX_TAP     = 400;
    localparam int unsigned VTC_WAIT    = 10;
    localparam int unsigned SETTLE_WAIT = 4;
    localparam int unsigned RETRIES     = 1;
    localparam int          BUDGET      = 200;

    logic clk_div = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_div = ~clk_div;

    delay_tap_loader_if #(.TAP_W(TAP_W)) bus ();

    delay_tap_loader #(
        .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .VTC_WAIT(VTC_WAIT),
        .SETTLE_WAIT(SETTLE_WAIT), .RETRIES(RETRIES)
    ) dut (
        .clk_div(clk_div),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    logic prev_load = 1'b0;
    logic [TAP_W-1:0] model_cur = '0;
    logic             model_err = 1'b0;

    // LOAD must be a single-cycle pulse and only while VTC is disabled
    always @(negedge clk_div) begin
        if (bus.dly_load && bus.dly_en_vtc) viol++;
        if (bus.dly_load && prev_load) viol++;
        prev_load = bus.dly_load;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [TAP_W-1:0] ref_target(input int unsigned tap);
        return (tap > MAX_TAP) ? TAP_W'(MAX_TAP) : TAP_W'(tap);
    endfunction

    // mode 0: element echoes, 1: wrong on first load only, 2: always wrong
    function automatic int ref_loads(input int mode);
        if (mode == 0) return 1;
        if (mode == 1) return (RETRIES >= 1) ? 2 : 1;
        return 1 + int'(RETRIES);
    endfunction

    // acceptance -> done: VTC off, load, settle (+1 take-up cycle), check; each retry repeats load/settle/check
    function automatic int ref_latency(input int loads);
        return int'(VTC_WAIT + SETTLE_WAIT + 3) + (loads - 1) * int'(SETTLE_WAIT + 3);
    endfunction

    function automatic void ref_apply(input int unsigned tap, input int mode);
        if (mode == 2 || (mode == 1 && RETRIES == 0)) model_err = 1'b1;
        else model_cur = ref_target(tap);
    endfunction

    // ---------------- request driver with element model ----------------
    task automatic run_req(input int unsigned tap, input int mode, input int clr_at,
                           output int lat, output int loads, output logic [TAP_W-1:0] first_val,
                           output logic clamp_seen, output int vtc_low_pre);
        @(negedge clk_div);
        bus.req_valid       = 1'b1;
        bus.req_tap         = TAP_W'(tap);
        bus.dly_cntvalueout = ref_target(tap) ^ TAP_W'(10'h3F0);
        @(posedge clk_div); #1;
        bus.req_valid = 1'b0;
        clamp_seen  = bus.clamped;
        lat         = -1;
        loads       = 0;
        first_val   = '0;
        vtc_low_pre = 0;
        for (int k = 0; k <= BUDGET; k++) begin
            if (k > 0) begin @(posedge clk_div); #1; end
            if (bus.dly_load) begin
                if (loads == 0) first_val = bus.dly_cntvaluein;
                loads++;
                if (mode == 2 || (mode == 1 && loads == 1))
                    bus.dly_cntvalueout = bus.dly_cntvaluein ^ TAP_W'(1);
                else
                    bus.dly_cntvalueout = bus.dly_cntvaluein;
            end else if (loads == 0 && !bus.dly_en_vtc) begin
                vtc_low_pre++;
            end
            bus.err_clr = (k == clr_at);
            if (bus.done) begin lat = k; break; end
        end
        bus.err_clr = 1'b0;
        @(posedge clk_div); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        tests++; if (bus.dly_en_vtc !== 1'b1) begin fails++; $display("FAIL reset_en_vtc: got %b want 1", bus.dly_en_vtc); end
        tests++; if (bus.dly_load !== 1'b0) begin fails++; $display("FAIL reset_load: got %b want 0", bus.dly_load); end
        tests++; if (bus.dly_cntvaluein !== '0) begin fails++; $display("FAIL reset_cntin: got %0d want 0", bus.dly_cntvaluein); end
        tests++; if (bus.cur_tap !== '0) begin fails++; $display("FAIL reset_cur_tap: got %0d want 0", bus.cur_tap); end
        tests++; if ({bus.done, bus.clamped, bus.err_sticky} !== 3'b000) begin fails++; $display("FAIL reset_status: got %b want 000", {bus.done, bus.clamped, bus.err_sticky}); end
    endtask

    task automatic test_basic();
        int lat, loads, vlow; logic [TAP_W-1:0] fv; logic cl;
        run_req(9, 0, -1, lat, loads, fv, cl, vlow);
        ref_apply(9, 0);
        tests++; if (lat !== ref_latency(1)) begin fails++; $display("FAIL basic_latency: got %0d want %0d", lat, ref_latency(1)); end
        tests++; if (loads !== 1) begin fails++; $display("FAIL basic_loads: got %0d want 1", loads); end
        tests++; if (fv !== TAP_W'(9)) begin fails++; $display("FAIL basic_cntin: got %0d want 9", fv); end
        tests++; if (vlow !== int'(VTC_WAIT)) begin fails++; $display("FAIL basic_vtc_low: got %0d want %0d", vlow, VTC_WAIT); end
        tests++; if (bus.cur_tap !== model_cur) begin fails++; $display("FAIL basic_cur_tap: got %0d want %0d", bus.cur_tap, model_cur); end
        tests++; if ({cl, bus.err_sticky} !== 2'b00) begin fails++; $display("FAIL basic_flags: got %b want 00", {cl, bus.err_sticky}); end
        tests++; if ({bus.req_ready, bus.dly_en_vtc} !== 2'b11) begin fails++; $display("FAIL basic_idle: got %b want 11", {bus.req_ready, bus.dly_en_vtc}); end
    endtask

    task automatic test_clamp();
        int unsigned taps [4] = '{600, MAX_TAP, 0, MAX_TAP + 1};
        int lat, loads, vlow; logic [TAP_W-1:0] fv; logic cl;
        foreach (taps[i]) begin
            run_req(taps[i], 0, -1, lat, loads, fv, cl, vlow);
            ref_apply(taps[i], 0);
            tests++; if (cl !== (taps[i] > MAX_TAP)) begin fails++; $display("FAIL clamp_pulse[%0d]: got %b want %b", taps[i], cl, taps[i] > MAX_TAP); end
            tests++; if (fv !== ref_target(taps[i])) begin fails++; $display("FAIL clamp_cntin[%0d]: got %0d want %0d", taps[i], fv, ref_target(taps[i])); end
            tests++; if (bus.cur_tap !== model_cur) begin fails++; $display("FAIL clamp_cur_tap[%0d]: got %0d want %0d", taps[i], bus.cur_tap, model_cur); end
        end
    endtask

    task automatic test_retry();
        int lat, loads, vlow; logic [TAP_W-1:0] fv; logic cl;
        int unsigned tap = $urandom_range(1, MAX_TAP);
        run_req(tap, 1, -1, lat, loads, fv, cl, vlow);
        ref_apply(tap, 1);
        tests++; if (loads !== ref_loads(1)) begin fails++; $display("FAIL retry_loads: got %0d want %0d", loads, ref_loads(1)); end
        tests++; if (lat !== ref_latency(ref_loads(1))) begin fails++; $display("FAIL retry_latency: got %0d want %0d", lat, ref_latency(ref_loads(1))); end
        tests++; if (bus.err_sticky !== model_err) begin fails++; $display("FAIL retry_err: got %b want %b", bus.err_sticky, model_err); end
        tests++; if (bus.cur_tap !== model_cur) begin fails++; $display("FAIL retry_cur_tap: got %0d want %0d", bus.cur_tap, model_cur); end
    endtask

    task automatic test_always_wrong();
        int lat, loads, vlow; logic [TAP_W-1:0] fv; logic cl;
        int unsigned tap = $urandom_range(0, MAX_TAP);
        if (ref_target(tap) == model_cur) tap = (model_cur == 0) ? 5 : 0;
        run_req(tap, 2, -1, lat, loads, fv, cl, vlow);
        ref_apply(tap, 2);
        tests++; if (loads !== ref_loads(2)) begin fails++; $display("FAIL wrong_loads: got %0d want %0d", loads, ref_loads(2)); end
        tests++; if (lat !== ref_latency(ref_loads(2))) begin fails++; $display("FAIL wrong_latency: got %0d want %0d", lat, ref_latency(ref_loads(2))); end
        tests++; if (bus.err_sticky !== 1'b1) begin fails++; $display("FAIL wrong_err_set: got %b want 1", bus.err_sticky); end
        tests++; if (bus.cur_tap !== model_cur) begin fails++; $display("FAIL wrong_cur_tap: got %0d want %0d", bus.cur_tap, model_cur); end
        @(negedge clk_div); bus.err_clr = 1'b1;
        @(negedge clk_div); bus.err_clr = 1'b0;
        model_err = 1'b0;
        tests++; if (bus.err_sticky !== 1'b0) begin fails++; $display("FAIL wrong_err_clr: got %b want 0", bus.err_sticky); end
    endtask

    task automatic test_set_wins();
        int lat, loads, vlow; logic [TAP_W-1:0] fv; logic cl;
        // err_clr asserted in the final CHECK cycle, i.e. the cycle before done
        run_req(77, 2, ref_latency(ref_loads(2)) - 1, lat, loads, fv, cl, vlow);
        ref_apply(77, 2);
        tests++; if (bus.err_sticky !== 1'b1) begin fails++; $display("FAIL set_wins: got %b want 1", bus.err_sticky); end
        @(negedge clk_div); bus.err_clr = 1'b1;
        @(negedge clk_div); bus.err_clr = 1'b0;
        model_err = 1'b0;
        tests++; if (bus.err_sticky !== 1'b0) begin fails++; $display("FAIL set_wins_clr: got %b want 0", bus.err_sticky); end
    endtask

    task automatic test_back_to_back();
        int unsigned a = $urandom_range(0, 199);
        int unsigned b = $urandom_range(200, 1023);
        int loads_a = 0, loads_b = 0;
        logic [TAP_W-1:0] va = '0, vb = '0;
        logic got_done = 1'b0;
        @(negedge clk_div);
        bus.req_valid = 1'b1; bus.req_tap = TAP_W'(a);
        @(posedge clk_div); #1;
        bus.req_tap = TAP_W'(b);
        for (int k = 0; k <= BUDGET && !got_done; k++) begin
            if (k > 0) begin @(posedge clk_div); #1; end
            if (bus.dly_load) begin if (loads_a == 0) va = bus.dly_cntvaluein; loads_a++; bus.dly_cntvalueout = bus.dly_cntvaluein; end
            got_done = bus.done;
        end
        ref_apply(a, 0);
        tests++; if (got_done !== 1'b1) begin fails++; $display("FAIL b2b_done_a: got %b want 1", got_done); end
        tests++; if (loads_a !== 1 || va !== ref_target(a)) begin fails++; $display("FAIL b2b_first: got loads %0d val %0d want 1 / %0d", loads_a, va, ref_target(a)); end
        @(posedge clk_div); #1;
        tests++; if (bus.req_ready !== 1'b1 || bus.cur_tap !== model_cur) begin fails++; $display("FAIL b2b_idle: got ready %b cur %0d want 1 / %0d", bus.req_ready, bus.cur_tap, model_cur); end
        @(posedge clk_div); #1;
        bus.req_valid = 1'b0;
        got_done = 1'b0;
        for (int k = 0; k <= BUDGET && !got_done; k++) begin
            if (k > 0) begin @(posedge clk_div); #1; end
            if (bus.dly_load) begin if (loads_b == 0) vb = bus.dly_cntvaluein; loads_b++; bus.dly_cntvalueout = bus.dly_cntvaluein; end
            got_done = bus.done;
        end
        @(posedge clk_div); #1;
        ref_apply(b, 0);
        tests++; if (loads_b !== 1 || vb !== ref_target(b)) begin fails++; $display("FAIL b2b_second: got loads %0d val %0d want 1 / %0d", loads_b, vb, ref_target(b)); end
        tests++; if (bus.cur_tap !== model_cur) begin fails++; $display("FAIL b2b_cur_tap: got %0d want %0d", bus.cur_tap, model_cur); end
    endtask

    task automatic test_reset_mid();
        int lat, loads, vlow; logic [TAP_W-1:0] fv; logic cl;
        logic saw_done = 1'b0;
        @(negedge clk_div);
        bus.req_valid = 1'b1; bus.req_tap = TAP_W'(123);
        @(posedge clk_div); #1;
        bus.req_valid = 1'b0;
        // edges 11..15 after acceptance are the SETTLE window
        repeat (12) @(posedge clk_div);
        #2;
        rst_n = 1'b0;
        #1;
        model_cur = '0; model_err = 1'b0;
        tests++; if ({bus.req_ready, bus.dly_en_vtc, bus.dly_load} !== 3'b110) begin fails++; $display("FAIL rstmid_ctrl: got %b want 110", {bus.req_ready, bus.dly_en_vtc, bus.dly_load}); end
        tests++; if (bus.dly_cntvaluein !== '0 || bus.cur_tap !== '0) begin fails++; $display("FAIL rstmid_values: got cntin %0d cur %0d want 0 / 0", bus.dly_cntvaluein, bus.cur_tap); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_div); #1;
            if (bus.done) saw_done = 1'b1;
        end
        @(negedge clk_div); rst_n = 1'b1;
        repeat (3) begin @(posedge clk_div); #1; if (bus.done) saw_done = 1'b1; end
        tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL rstmid_no_done: got %b want 0", saw_done); end
        run_req(321, 0, -1, lat, loads, fv, cl, vlow);
        ref_apply(321, 0);
        tests++; if (lat !== ref_latency(1) || bus.cur_tap !== model_cur) begin fails++; $display("FAIL rstmid_fresh: got lat %0d cur %0d want %0d / %0d", lat, bus.cur_tap, ref_latency(1), model_cur); end
    endtask

    task automatic test_random();
        int lat, loads, vlow; logic [TAP_W-1:0] fv; logic cl;
        for (int i = 0; i < 10; i++) begin
            int unsigned tap  = $urandom_range(0, (1 << TAP_W) - 1);
            int          mode = int'($urandom_range(0, 2));
            run_req(tap, mode, -1, lat, loads, fv, cl, vlow);
            ref_apply(tap, mode);
            tests++; if (lat !== ref_latency(ref_loads(mode)) || loads !== ref_loads(mode)) begin fails++; $display("FAIL rand_timing[%0d]: got lat %0d loads %0d want %0d / %0d", i, lat, loads, ref_latency(ref_loads(mode)), ref_loads(mode)); end
            tests++; if (fv !== ref_target(tap) || cl !== (tap > MAX_TAP)) begin fails++; $display("FAIL rand_target[%0d]: got %0d clamp %b want %0d / %b", i, fv, cl, ref_target(tap), tap > MAX_TAP); end
            tests++; if (bus.cur_tap !== model_cur || bus.err_sticky !== model_err) begin fails++; $display("FAIL rand_status[%0d]: got cur %0d err %b want %0d / %b", i, bus.cur_tap, bus.err_sticky, model_cur, model_err); end
            if (model_err) begin
                @(negedge clk_div); bus.err_clr = 1'b1;
                @(negedge clk_div); bus.err_clr = 1'b0;
                model_err = 1'b0;
            end
        end
    endtask

    task automatic test_load_invariants();
        tests++; if (viol !== 0) begin fails++; $display("FAIL load_invariants: got %0d violations want 0", viol); end
    endtask

    initial begin
        bus.req_valid       = 1'b0;
        bus.req_tap         = '0;
        bus.err_clr         = 1'b0;
        bus.dly_cntvalueout = '0;
        repeat (3) @(posedge clk_div);
        #1;
        test_reset();
        @(negedge clk_div); rst_n = 1'b1;
        test_basic();
        test_clamp();
        test_retry();
        test_always_wrong();
        test_set_wins();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_load_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
